// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath: operand/accumulator widths and
// the operand sequencer state encoding.
package mac_pkg;

  localparam int MAC_DATA_W = 8;
  localparam int MAC_ACC_W  = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    FEED  = 2'd2,
    DRAIN = 2'd3
  } seq_state_t;

endpackage

// File: rtl/mac_operand_sequencer.sv
// Pops operand pairs from two FWFT FIFOs into the pipelined MAC for a
// programmed vector length, then waits out the MAC latency and captures Cout.
module mac_operand_sequencer
  import mac_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  input  logic                  abort,
  input  logic                  a_empty,
  input  logic [MAC_DATA_W-1:0] a_rdata,
  output logic                  a_rden,
  input  logic                  b_empty,
  input  logic [MAC_DATA_W-1:0] b_rdata,
  output logic                  b_rden,
  output logic                  mac_en,
  output logic                  mac_clr,
  output logic [MAC_DATA_W-1:0] mac_a,
  output logic [MAC_DATA_W-1:0] mac_b,
  input  logic [MAC_ACC_W-1:0]  mac_cout,
  output logic [MAC_ACC_W-1:0]  result,
  output logic                  result_valid,
  output logic                  busy
);

  localparam int DRAIN_W = $clog2(MAC_LAT + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MAC_LAT - 1);

  seq_state_t            state_r, state_s;
  logic [LEN_W-1:0]      remaining_r, remaining_s;
  logic [DRAIN_W-1:0]    drain_cnt_r, drain_cnt_s;
  logic                  mac_en_r, mac_en_s;
  logic                  mac_clr_r, mac_clr_s;
  logic [MAC_DATA_W-1:0] mac_a_r, mac_a_s;
  logic [MAC_DATA_W-1:0] mac_b_r, mac_b_s;
  logic [MAC_ACC_W-1:0]  result_r, result_s;
  logic                  result_valid_r, result_valid_s;
  logic                  busy_r, busy_s;
  logic                  pop_s;

  // Pop both FIFOs together, only while feeding and never in an abort cycle
  always_comb begin
    pop_s = (state_r == FEED) && !abort && !a_empty && !b_empty &&
            (remaining_r != {LEN_W{1'b0}});
  end

  // Next-state and next-output logic for the sequencer FSM
  always_comb begin
    state_s        = state_r;
    remaining_s    = remaining_r;
    drain_cnt_s    = drain_cnt_r;
    mac_en_s       = 1'b0;
    mac_clr_s      = 1'b0;
    mac_a_s        = mac_a_r;
    mac_b_s        = mac_b_r;
    result_s       = result_r;
    result_valid_s = 1'b0;
    busy_s         = busy_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (len != {LEN_W{1'b0}}) begin
            remaining_s = len;
            mac_clr_s   = 1'b1;
            busy_s      = 1'b1;
            state_s     = CLEAR;
          end else begin
            result_s       = {MAC_ACC_W{1'b0}};
            result_valid_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CLEAR: begin
        if (abort) begin
          remaining_s = {LEN_W{1'b0}};
          mac_clr_s   = 1'b1;
          busy_s      = 1'b0;
          state_s     = IDLE;
        end else begin
          state_s = FEED;
        end
      end
      FEED: begin
        if (abort) begin
          remaining_s = {LEN_W{1'b0}};
          mac_clr_s   = 1'b1;
          busy_s      = 1'b0;
          state_s     = IDLE;
        end else if (pop_s) begin
          mac_a_s     = a_rdata;
          mac_b_s     = b_rdata;
          mac_en_s    = 1'b1;
          remaining_s = remaining_r - LEN_W'(1);
          if (remaining_r == LEN_W'(1)) begin
            drain_cnt_s = {DRAIN_W{1'b0}};
            state_s     = DRAIN;
          end else begin
            state_s = FEED;
          end
        end else begin
          state_s = FEED;
        end
      end
      DRAIN: begin
        if (abort) begin
          remaining_s = {LEN_W{1'b0}};
          mac_clr_s   = 1'b1;
          busy_s      = 1'b0;
          state_s     = IDLE;
        end else if (drain_cnt_r == DRAIN_LAST) begin
          // mac_cout holds the final sum in the last drain cycle
          result_s       = mac_cout;
          result_valid_s = 1'b1;
          busy_s         = 1'b0;
          state_s        = IDLE;
        end else begin
          drain_cnt_s = drain_cnt_r + DRAIN_W'(1);
        end
      end
      default: begin
        remaining_s = {LEN_W{1'b0}};
        busy_s      = 1'b0;
        state_s     = IDLE;
      end
    endcase
  end

  // State and registered-output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      remaining_r    <= {LEN_W{1'b0}};
      drain_cnt_r    <= {DRAIN_W{1'b0}};
      mac_en_r       <= 1'b0;
      mac_clr_r      <= 1'b0;
      mac_a_r        <= {MAC_DATA_W{1'b0}};
      mac_b_r        <= {MAC_DATA_W{1'b0}};
      result_r       <= {MAC_ACC_W{1'b0}};
      result_valid_r <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      remaining_r    <= remaining_s;
      drain_cnt_r    <= drain_cnt_s;
      mac_en_r       <= mac_en_s;
      mac_clr_r      <= mac_clr_s;
      mac_a_r        <= mac_a_s;
      mac_b_r        <= mac_b_s;
      result_r       <= result_s;
      result_valid_r <= result_valid_s;
      busy_r         <= busy_s;
    end
  end

  assign a_rden       = pop_s;
  assign b_rden       = pop_s;
  assign mac_en       = mac_en_r;
  assign mac_clr      = mac_clr_r;
  assign mac_a        = mac_a_r;
  assign mac_b        = mac_b_r;
  assign result       = result_r;
  assign result_valid = result_valid_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed bench: FWFT FIFO and 3-cycle MAC models around the sequencer,
// checked with immediate assertions against hand-computed values.
module tb_mac_operand_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = 8'd0;
  logic        abort = 1'b0;
  logic        a_empty, b_empty;
  logic [7:0]  a_rdata, b_rdata;
  logic        a_rden, b_rden;
  logic        mac_en, mac_clr;
  logic [7:0]  mac_a, mac_b;
  logic [23:0] mac_cout;
  logic [23:0] result;
  logic        result_valid, busy;

  logic [7:0]  a_mem [64];
  logic [7:0]  b_mem [64];
  int          a_cnt = 0, b_cnt = 0;
  int          a_idx = 0, b_idx = 0;
  logic        b_block = 1'b0;
  logic        flush = 1'b0;
  int          a_pops = 0, b_pops = 0, en_cnt = 0, clr_cnt = 0, rv_cnt = 0;
  int          cyc = 0, en_last = 0;
  logic [23:0] acc_r = 24'd0, cout_r = 24'd0;

  int errors = 0;
  int checks = 0;

  mac_operand_sequencer #(.LEN_W(8), .MAC_LAT(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
    .a_empty(a_empty), .a_rdata(a_rdata), .a_rden(a_rden),
    .b_empty(b_empty), .b_rdata(b_rdata), .b_rden(b_rden),
    .mac_en(mac_en), .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b),
    .mac_cout(mac_cout), .result(result), .result_valid(result_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  assign a_empty  = (a_idx >= a_cnt);
  assign b_empty  = (b_idx >= b_cnt) || b_block;
  assign a_rdata  = a_mem[a_idx[5:0]];
  assign b_rdata  = b_mem[b_idx[5:0]];
  assign mac_cout = cout_r;

  // FIFO pointers and event counters
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (flush) begin
      a_idx <= a_cnt;
      b_idx <= b_cnt;
    end else begin
      if (a_rden) begin a_idx <= a_idx + 1; a_pops <= a_pops + 1; end
      if (b_rden) begin b_idx <= b_idx + 1; b_pops <= b_pops + 1; end
    end
    if (mac_en) begin en_cnt <= en_cnt + 1; en_last <= cyc; end
    if (mac_clr) clr_cnt <= clr_cnt + 1;
    if (result_valid) rv_cnt <= rv_cnt + 1;
  end

  // MAC model: accumulator stage plus one output stage
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r  <= 24'd0;
      cout_r <= 24'd0;
    end else begin
      if (mac_clr) acc_r <= 24'd0;
      else if (mac_en) acc_r <= acc_r + 24'(mac_a) * 24'(mac_b);
      cout_r <= acc_r;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    a_mem[a_cnt] = a;
    b_mem[b_cnt] = b;
    a_cnt++;
    b_cnt++;
  endtask

  task automatic wait_rv(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!result_valid && n < max);
    chk("rv_timeout", {31'd0, result_valid}, 32'd1);
  endtask

  int base, ap0, bp0, en0, clr0, rv0, n;

  initial begin
    // Reset
    step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_clr", {31'd0, mac_clr}, 32'd0);
    chk("rst_result", {8'd0, result}, 32'd0);
    chk("rst_rden", {31'd0, a_rden}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Test 1: len=4, no stalls
    push(8'd1, 8'd5); push(8'd2, 8'd6); push(8'd3, 8'd7); push(8'd4, 8'd8);
    base = cyc; ap0 = a_pops; bp0 = b_pops; en0 = en_cnt; clr0 = clr_cnt;
    start = 1'b1; len = 8'd4;
    chk("t1_busy_c0", {31'd0, busy}, 32'd0);
    step(); start = 1'b0;
    chk("t1_clr_c1", {31'd0, mac_clr}, 32'd1);
    chk("t1_busy_c1", {31'd0, busy}, 32'd1);
    chk("t1_rden_c1", {31'd0, a_rden}, 32'd0);
    step();
    chk("t1_clr_c2", {31'd0, mac_clr}, 32'd0);
    chk("t1_arden_c2", {31'd0, a_rden}, 32'd1);
    chk("t1_brden_c2", {31'd0, b_rden}, 32'd1);
    chk("t1_en_c2", {31'd0, mac_en}, 32'd0);
    step();
    chk("t1_en_c3", {31'd0, mac_en}, 32'd1);
    chk("t1_maca_c3", {24'd0, mac_a}, 32'd1);
    chk("t1_macb_c3", {24'd0, mac_b}, 32'd5);
    wait_rv(20, n);
    chk("t1_rv_cycle", n, 32'd6);
    chk("t1_result", {8'd0, result}, 32'd70);
    chk("t1_busy_end", {31'd0, busy}, 32'd0);
    chk("t1_apops", a_pops - ap0, 32'd4);
    chk("t1_bpops", b_pops - bp0, 32'd4);
    chk("t1_en_cnt", en_cnt - en0, 32'd4);
    chk("t1_en_last", en_last - base, 32'd6);
    chk("t1_clr_cnt", clr_cnt - clr0, 32'd1);
    step();
    chk("t1_rv_pulse", {31'd0, result_valid}, 32'd0);
    chk("t1_hold", {8'd0, result}, 32'd70);

    // Test 2: len=3 of 255s with B empty for 2 cycles after first pop
    push(8'd255, 8'd255); push(8'd255, 8'd255); push(8'd255, 8'd255);
    base = cyc; en0 = en_cnt;
    start = 1'b1; len = 8'd3;
    step(); start = 1'b0;
    step();
    chk("t2_pop_c2", {31'd0, a_rden}, 32'd1);
    step(); b_block = 1'b1; #1;
    chk("t2_stall_c3", {31'd0, a_rden}, 32'd0);
    step();
    chk("t2_stall_c4", {31'd0, b_rden}, 32'd0);
    chk("t2_bubble_c4", {31'd0, mac_en}, 32'd0);
    step(); b_block = 1'b0;
    wait_rv(20, n);
    chk("t2_rv_cycle", n, 32'd5);
    chk("t2_result", {8'd0, result}, 32'd195075);
    chk("t2_en_cnt", en_cnt - en0, 32'd3);
    chk("t2_en_last", en_last - base, 32'd7);
    step();

    // Test 3: zero-length start
    ap0 = a_pops; clr0 = clr_cnt;
    push(8'd9, 8'd9);
    start = 1'b1; len = 8'd0;
    step(); start = 1'b0;
    chk("t3_rv", {31'd0, result_valid}, 32'd1);
    chk("t3_result", {8'd0, result}, 32'd0);
    chk("t3_busy", {31'd0, busy}, 32'd0);
    chk("t3_clr", {31'd0, mac_clr}, 32'd0);
    step();
    chk("t3_rv_pulse", {31'd0, result_valid}, 32'd0);
    chk("t3_pops", a_pops - ap0, 32'd0);
    chk("t3_clr_cnt", clr_cnt - clr0, 32'd0);
    flush = 1'b1; step(); flush = 1'b0;

    // Test 4: len=5, abort in third FEED cycle, then len=1 run
    for (int i = 0; i < 5; i++) push(8'd6, 8'd6);
    ap0 = a_pops; rv0 = rv_cnt;
    start = 1'b1; len = 8'd5;
    step(); start = 1'b0;
    step(); step(); step();
    clr0 = clr_cnt;
    abort = 1'b1; #1;
    chk("t4_abort_nopop", {31'd0, a_rden}, 32'd0);
    step(); abort = 1'b0;
    chk("t4_clr", {31'd0, mac_clr}, 32'd1);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_rv", {31'd0, result_valid}, 32'd0);
    chk("t4_pops", a_pops - ap0, 32'd2);
    step();
    chk("t4_clr_once", clr_cnt - clr0, 32'd1);
    chk("t4_rv_none", rv_cnt - rv0, 32'd0);
    flush = 1'b1; step(); flush = 1'b0;
    push(8'd3, 8'd4);
    start = 1'b1; len = 8'd1;
    step(); start = 1'b0;
    wait_rv(20, n);
    chk("t4_len1_result", {8'd0, result}, 32'd12);
    step();

    // Test 5: start during FEED ignored, reset in DRAIN
    push(8'd2, 8'd3); push(8'd2, 8'd3); push(8'd2, 8'd3);
    ap0 = a_pops; rv0 = rv_cnt;
    start = 1'b1; len = 8'd3;
    step(); start = 1'b0;
    step(); step();
    start = 1'b1; len = 8'd1;
    step(); start = 1'b0;
    chk("t5_busy_c4", {31'd0, busy}, 32'd1);
    step();
    chk("t5_pops", a_pops - ap0, 32'd3);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_result", {8'd0, result}, 32'd0);
    chk("t5_rst_maca", {24'd0, mac_a}, 32'd0);
    chk("t5_rst_en", {31'd0, mac_en}, 32'd0);
    chk("t5_rst_rden", {31'd0, a_rden}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step(); step(); step(); step();
    chk("t5_no_rv", rv_cnt - rv0, 32'd0);

    // Test 6: back-to-back runs; abort together with start in IDLE
    push(8'd10, 8'd1); push(8'd20, 8'd1); push(8'd7, 8'd2); push(8'd7, 8'd2);
    start = 1'b1; len = 8'd2; abort = 1'b1;
    step(); start = 1'b0; abort = 1'b0;
    chk("t6_start_wins", {31'd0, busy}, 32'd1);
    wait_rv(20, n);
    chk("t6_rv1_cycle", n, 32'd6);
    chk("t6_result1", {8'd0, result}, 32'd30);
    clr0 = clr_cnt;
    start = 1'b1; len = 8'd2;
    step(); start = 1'b0;
    chk("t6_clr2", {31'd0, mac_clr}, 32'd1);
    wait_rv(20, n);
    chk("t6_result2", {8'd0, result}, 32'd28);
    chk("t6_clr_cnt", clr_cnt - clr0, 32'd1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
